// File: rtl/axis_read_ctrl_pkg.sv
// Shared types and constants for the read-command sequencer.
// State indices, the one-hot state encoding and the command FIFO entry width live here.
package axis_read_ctrl_pkg;

  localparam int unsigned S_IDLE   = 0;
  localparam int unsigned S_ID     = 1;
  localparam int unsigned S_ADDR   = 2;
  localparam int unsigned S_LEN    = 3;
  localparam int unsigned S_STREAM = 4;
  localparam int unsigned S_DONE   = 5;

  localparam int unsigned NUM_STATES        = 6;
  localparam int unsigned DEF_CONFIG_DWIDTH = 32;
  localparam int unsigned CMD_ENTRY_WIDTH   = 2 * DEF_CONFIG_DWIDTH;

  typedef enum logic [NUM_STATES-1:0] {
    StIdle   = NUM_STATES'(1 << S_IDLE),
    StId     = NUM_STATES'(1 << S_ID),
    StAddr   = NUM_STATES'(1 << S_ADDR),
    StLen    = NUM_STATES'(1 << S_LEN),
    StStream = NUM_STATES'(1 << S_STREAM),
    StDone   = NUM_STATES'(1 << S_DONE)
  } state_e;

  // FIFO entry is {addr, length}.
  function automatic int unsigned cmd_entry_width(input int unsigned dwidth);
    return 2 * dwidth;
  endfunction

endpackage

// File: rtl/axis_read_ctrl_if.sv
// Bundle of command, config-bus and observed-stream signals around the read sequencer.
interface axis_read_ctrl_if #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 32
);
  logic [DWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_length;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AWIDTH-1:0] cfg_addr;
  logic [DWIDTH-1:0] cfg_data;
  logic              cfg_valid;
  logic              strm_valid;
  logic              strm_ready;
  logic              busy;
  logic              done;

  modport master (
    output cmd_addr, cmd_length, cmd_valid, strm_valid, strm_ready,
    input  cmd_ready, cfg_addr, cfg_data, cfg_valid, busy, done
  );

  modport slave (
    input  cmd_addr, cmd_length, cmd_valid, strm_valid, strm_ready,
    output cmd_ready, cfg_addr, cfg_data, cfg_valid, busy, done
  );
endinterface

// File: rtl/axis_cmd_fifo.sv
// Single-clock FIFO with first-word-fall-through output and registered full flag.
module axis_cmd_fifo
  import axis_read_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = CMD_ENTRY_WIDTH,
  parameter int unsigned AWIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_wvalid,
  output logic             o_wready,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  input  logic             i_rready
);
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_count;
  logic              r_full;
  logic              w_push;
  logic              w_pop;
  logic [AWIDTH:0]   w_count_next;

  assign w_push       = i_wvalid & ~r_full;
  assign w_pop        = i_rready & (r_count != '0);
  assign w_count_next = r_count + (AWIDTH+1)'(w_push) - (AWIDTH+1)'(w_pop);

  assign o_wready = ~r_full;
  assign o_rvalid = (r_count != '0);
  assign o_rdata  = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AWIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + AWIDTH'(1);
      r_count <= w_count_next;
      // Full is registered so ready drops the cycle after the last slot is written.
      r_full  <= (w_count_next == (AWIDTH+1)'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/axis_read_ctrl.sv
// Read-command sequencer: queues {addr, length}, writes the three-beat engine config,
// then counts stream handshakes and pulses done after exactly length words.
module axis_read_ctrl
  import axis_read_ctrl_pkg::*;
#(
  parameter int unsigned CMD_AWIDTH    = 2,
  parameter int unsigned CONFIG_ID     = 1,
  parameter int unsigned CONFIG_ADDR   = 23,
  parameter int unsigned CONFIG_DATA   = 24,
  parameter int unsigned CONFIG_AWIDTH = 5,
  parameter int unsigned CONFIG_DWIDTH = 32
) (
  input logic            i_clk,
  input logic            i_rst,
  axis_read_ctrl_if.slave io_bus
);
  localparam int unsigned EW = cmd_entry_width(CONFIG_DWIDTH);

  state_e                   r_state;
  logic [CONFIG_DWIDTH-1:0] r_cur_addr;
  logic [CONFIG_DWIDTH-1:0] r_cur_len;
  logic [CONFIG_DWIDTH-1:0] r_beat_cnt;
  logic                     r_cfg_valid;
  logic [CONFIG_AWIDTH-1:0] r_cfg_addr;
  logic [CONFIG_DWIDTH-1:0] r_cfg_data;

  logic [EW-1:0]            w_head;
  logic                     w_head_valid;
  logic                     w_pop_req;
  logic [CONFIG_DWIDTH-1:0] w_head_addr;
  logic [CONFIG_DWIDTH-1:0] w_head_len;
  logic                     w_count;
  logic [CONFIG_DWIDTH-1:0] w_cnt_next;
  logic                     w_reached;

  axis_cmd_fifo #(
    .WIDTH  (EW),
    .AWIDTH (CMD_AWIDTH)
  ) u_cmd_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wdata  ({io_bus.cmd_addr, io_bus.cmd_length}),
    .i_wvalid (io_bus.cmd_valid),
    .o_wready (io_bus.cmd_ready),
    .o_rdata  (w_head),
    .o_rvalid (w_head_valid),
    .i_rready (w_pop_req)
  );

  assign w_pop_req   = r_state[S_IDLE];
  assign w_head_addr = w_head[EW-1:CONFIG_DWIDTH];
  assign w_head_len  = w_head[CONFIG_DWIDTH-1:0];

  // Count saturates at cur_len so early beats can never overshoot the exit compare.
  assign w_count    = (r_state[S_ID] | r_state[S_ADDR] | r_state[S_LEN] | r_state[S_STREAM]) &
                      io_bus.strm_valid & io_bus.strm_ready & (r_beat_cnt != r_cur_len);
  assign w_cnt_next = r_beat_cnt + CONFIG_DWIDTH'(w_count);
  assign w_reached  = (w_cnt_next == r_cur_len);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_cur_len   <= '0;
      r_beat_cnt  <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
    end else begin
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      if (w_count) r_beat_cnt <= w_cnt_next;
      unique case (r_state)
        StIdle: begin
          if (w_head_valid) begin
            r_cur_addr <= w_head_addr;
            r_cur_len  <= w_head_len;
            r_state    <= StId;
            // Zero-length commands pass through ID silently and finish without config beats.
            if (w_head_len != '0) begin
              r_cfg_valid <= 1'b1;
              r_cfg_addr  <= CONFIG_AWIDTH'(CONFIG_ADDR);
              r_cfg_data  <= CONFIG_DWIDTH'(CONFIG_ID);
            end
          end
        end
        StId: begin
          if (r_cur_len == '0) begin
            r_state <= StDone;
          end else begin
            r_state     <= StAddr;
            r_cfg_valid <= 1'b1;
            r_cfg_addr  <= CONFIG_AWIDTH'(CONFIG_DATA);
            r_cfg_data  <= r_cur_addr;
          end
        end
        StAddr: begin
          r_state     <= StLen;
          r_cfg_valid <= 1'b1;
          r_cfg_addr  <= CONFIG_AWIDTH'(CONFIG_DATA);
          r_cfg_data  <= r_cur_len;
        end
        StLen: begin
          r_state <= w_reached ? StDone : StStream;
        end
        StStream: begin
          if (w_reached) r_state <= StDone;
        end
        StDone: begin
          r_beat_cnt <= '0;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.cfg_valid = r_cfg_valid;
  assign io_bus.cfg_addr  = r_cfg_addr;
  assign io_bus.cfg_data  = r_cfg_data;
  assign io_bus.busy      = ~r_state[S_IDLE];
  assign io_bus.done      = r_state[S_DONE];

endmodule

// File: tb/tb_axis_read_ctrl.sv
// Scoreboard bench for axis_read_ctrl: directed commands queue expected config beats and
// done cycles; a negedge monitor pops and compares whenever the DUT presents them.
module tb_axis_read_ctrl;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } cfg_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  cfg_t exp_cfg[$];
  int   exp_done[$];

  axis_read_ctrl_if #(.AWIDTH(5), .DWIDTH(32)) bus ();

  axis_read_ctrl #(
    .CMD_AWIDTH    (2),
    .CONFIG_ID     (1),
    .CONFIG_ADDR   (23),
    .CONFIG_DATA   (24),
    .CONFIG_AWIDTH (5),
    .CONFIG_DWIDTH (32)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic exp_cfg_seq(input int c, input logic [31:0] a, input logic [31:0] l);
    exp_cfg.push_back('{c, 5'd23, 32'd1});
    exp_cfg.push_back('{c + 1, 5'd24, a});
    exp_cfg.push_back('{c + 2, 5'd24, l});
  endtask

  // Holds the command until accepted; acc is the cycle in which the push lands.
  task automatic push_cmd(input logic [31:0] a, input logic [31:0] l, output int acc);
    bus.cmd_addr   = a;
    bus.cmd_length = l;
    bus.cmd_valid  = 1'b1;
    for (int n = 0; n < 64 && !bus.cmd_ready; n++) tick();
    acc = cyc;
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout cyc=%0d got cmd_ready=0 want 1", cyc);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic strm(input logic v, input logic r);
    bus.strm_valid = v;
    bus.strm_ready = r;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.cfg_valid === 1'b1) begin
        if (exp_cfg.size() == 0) begin
          errors++;
          $display("FAIL cfg_unexpected cyc=%0d got addr=%0d data=%h want no beat",
                   cyc, bus.cfg_addr, bus.cfg_data);
        end else begin
          cfg_t e;
          e = exp_cfg.pop_front();
          if (e.cyc != cyc || e.addr !== bus.cfg_addr || e.data !== bus.cfg_data) begin
            errors++;
            $display("FAIL cfg_beat got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                     cyc, bus.cfg_addr, bus.cfg_data, e.cyc, e.addr, e.data);
          end
        end
      end else if (bus.cfg_addr !== '0 || bus.cfg_data !== '0 || bus.cfg_valid !== 1'b0) begin
        errors++;
        $display("FAIL cfg_idle cyc=%0d got valid=%b addr=%0d data=%h want 0/0/0",
                 cyc, bus.cfg_valid, bus.cfg_addr, bus.cfg_data);
      end
      if (bus.done !== 1'b0) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got done=%b want 0", cyc, bus.done);
        end else begin
          int d;
          d = exp_done.pop_front();
          if (d != cyc || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle got cyc=%0d done=%b want cyc=%0d", cyc, bus.done, d);
          end
        end
      end
    end
  end

  initial begin
    int t;
    int t2;
    int f_acc;
    logic f_hit;
    logic beat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cmd_addr = '0;
    bus.cmd_length = '0;
    bus.cmd_valid = 1'b0;
    strm(1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b0;

    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
    chk("rst_cfg_addr", 32'(bus.cfg_addr), 32'd0);
    chk("rst_cfg_data", bus.cfg_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // Single command, consumer always ready.
    push_cmd(32'h1000, 32'd4, t);
    exp_cfg_seq(t + 2, 32'h1000, 32'd4);
    exp_done.push_back(t + 9);
    wait_until(t + 5);
    strm(1'b1, 1'b1);
    wait_until(t + 9);
    strm(1'b0, 1'b0);
    chk("single_busy_in_done", 32'(bus.busy), 32'd1);
    wait_until(t + 10);
    chk("single_busy_after", 32'(bus.busy), 32'd0);

    // Zero length: no config, done two cycles after the pop at t+1.
    push_cmd(32'h2222, 32'd0, t);
    exp_done.push_back(t + 3);
    wait_until(t + 6);
    chk("zero_busy_after", 32'(bus.busy), 32'd0);

    // Back-pressure: ready toggles 1010..., 8 handshakes at t+5, t+7, ... t+19.
    push_cmd(32'h3000, 32'd8, t);
    exp_cfg_seq(t + 2, 32'h3000, 32'd8);
    exp_done.push_back(t + 20);
    wait_until(t + 5);
    for (int i = 0; i < 16; i++) begin
      strm(1'b1, (i % 2) == 0);
      tick();
    end
    strm(1'b0, 1'b0);
    chk("bp_busy_after", 32'(bus.busy), 32'd0);

    // Early beat: handshake only in the LEN cycle, len=1.
    push_cmd(32'h55, 32'd1, t);
    exp_cfg_seq(t + 2, 32'h55, 32'd1);
    exp_done.push_back(t + 5);
    wait_until(t + 4);
    strm(1'b1, 1'b1);
    tick();
    strm(1'b0, 1'b0);
    wait_until(t + 7);
    chk("early_busy_after", 32'(bus.busy), 32'd0);

    // Queueing: A in flight, B..E fill the FIFO, F stalls until B is popped.
    push_cmd(32'hA0, 32'd1, t);
    exp_cfg_seq(t + 2, 32'hA0, 32'd1);
    exp_done.push_back(t + 9);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.cmd_addr   = 32'hB0 + 32'(16 * i);
      bus.cmd_length = 32'd1;
      bus.cmd_valid  = 1'b1;
      chk("q_ready_open", 32'(bus.cmd_ready), 32'd1);
      tick();
    end
    bus.cmd_addr = 32'hF0;
    chk("q_ready_full", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      exp_cfg_seq(t + 11 + 6 * i, 32'hB0 + 32'(16 * i), 32'd1);
      exp_done.push_back(t + 15 + 6 * i);
    end
    f_acc = -1;
    for (int n = 0; n < 40; n++) begin
      beat = (cyc == t + 8) ||
             (cyc >= t + 14 && cyc <= t + 38 && ((cyc - (t + 14)) % 6) == 0);
      strm(beat, beat);
      f_hit = bus.cmd_valid & bus.cmd_ready;
      if (f_hit) f_acc = cyc;
      tick();
      if (f_hit) bus.cmd_valid = 1'b0;
    end
    strm(1'b0, 1'b0);
    bus.cmd_valid = 1'b0;
    chk("q_f_accept_cycle", 32'(f_acc), 32'(t + 11));
    chk("q_busy_after", 32'(bus.busy), 32'd0);

    // Reset during STREAM after 2 of 6 beats, with one command still queued.
    push_cmd(32'h6000, 32'd6, t);
    exp_cfg_seq(t + 2, 32'h6000, 32'd6);
    bus.cmd_addr   = 32'hDEAD;
    bus.cmd_length = 32'd5;
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    wait_until(t + 5);
    strm(1'b1, 1'b1);
    tick();
    tick();
    strm(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    wait_until(t + 10);
    push_cmd(32'h2000, 32'd2, t2);
    exp_cfg_seq(t2 + 2, 32'h2000, 32'd2);
    exp_done.push_back(t2 + 7);
    wait_until(t2 + 5);
    strm(1'b1, 1'b1);
    tick();
    tick();
    strm(1'b0, 1'b0);
    wait_until(t2 + 12);
    chk("post_rst_busy_after", 32'(bus.busy), 32'd0);

    chk("cfg_queue_drained", 32'(exp_cfg.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
